// File: rtl/dslogic_pkg.sv
// Shared definitions for the capture-path blocks: pad word, packer FSM encoding
// and the default output-buffer depth.
package dslogic_pkg;

    localparam logic [15:0] RLE_PAD        = 16'h8000;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } rle_state_t;

endpackage

// File: rtl/rle_pack_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is only
// accepted when a read frees a slot in the same cycle.
module rle_pack_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH)
)(
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);
    assign level = count;
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    // Gated so the output reads zero whenever nothing is queued (incl. reset).
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (wr_ok && !clr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rle_pack.sv
// Packs pairs of 16-bit RLE words into 32-bit memory words, pads an odd tail
// on flush and buffers the result toward the memory writer.
module rle_pack
    import dslogic_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = 24
)(
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             rle_en,
    input  logic [15:0]      rle_data,
    input  logic             rle_valid,
    input  logic             flush,
    output logic [31:0]      mem_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow,
    output logic             flush_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    rle_state_t  state;
    rle_state_t  state_nxt;

    logic [15:0] half_data;
    logic        half_full;
    logic        push_req;
    logic [31:0] push_word;
    logic        accept;
    logic        pad_push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;

    assign mem_valid = !fifo_empty;
    assign pop       = mem_valid && mem_ready;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!rle_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (flush) state_nxt = FLUSH;
                FLUSH:   state_nxt = DRAIN;
                DRAIN:   if (fifo_level == '0 && !push_req) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        accept     = 1'b0;
        pad_push   = 1'b0;
        flush_done = 1'b0;
        case (state)
            RUN:     accept     = rle_valid;
            FLUSH:   pad_push   = half_full;
            DONE:    flush_done = 1'b1;
            default: ;
        endcase
    end

    // Pairs are staged one cycle in push_word, so a pair completed on the flush
    // cycle and the pad pushed from FLUSH never compete for the FIFO port.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            half_data <= '0;
            half_full <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
        end else if (!rle_en) begin
            half_data <= '0;
            half_full <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (accept) begin
                if (half_full) begin
                    push_req  <= 1'b1;
                    push_word <= {rle_data, half_data};
                    half_full <= 1'b0;
                end else begin
                    half_data <= rle_data;
                    half_full <= 1'b1;
                end
            end else if (pad_push) begin
                push_req  <= 1'b1;
                push_word <= {RLE_PAD, half_data};
                half_full <= 1'b0;
            end
            if (pop && word_cnt != '1)
                word_cnt <= word_cnt + CNT_W'(1);
            if (push_req && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    rle_pack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .clr      (!rle_en),
        .wr_en    (push_req),
        .wr_data  (push_word),
        .rd_en    (pop),
        .rd_data  (mem_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

endmodule
